// File: rtl/spike_aer_tx.sv
// AER transmitter: snapshots per-timestep spike vectors into an active/pending
// frame pair and serialises each set bit as an (address, timestamp) beat.
module spike_aer_tx #(
    parameter int N          = 96,
    parameter int TSW        = 16,
    parameter int EMIT_EMPTY = 0,
    parameter int DCW        = 16,
    localparam int AW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           step_valid,
    input  logic [N-1:0]   spikes_vec,
    output logic           aer_valid,
    input  logic           aer_ready,
    output logic [AW-1:0]  aer_addr,
    output logic [TSW-1:0] aer_ts,
    output logic           aer_last,
    output logic           aer_empty,
    output logic           busy,
    output logic [DCW-1:0] drop_cnt,
    output logic           drop_sticky,
    output logic           dbg_state
);

    // aer_valid/aer_ready: a beat transfers on any clk edge where both are high;
    // while aer_valid is high and aer_ready low, all beat fields hold steady.

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [N-1:0]   act_mask;
    logic [TSW-1:0] act_ts;
    logic           act_mk;
    logic           pend_valid;
    logic [N-1:0]   pend_mask;
    logic [TSW-1:0] pend_ts;
    logic           pend_mk;
    logic [TSW-1:0] ts_cnt;
    logic [DCW-1:0] drop_cnt_q;
    logic           drop_sticky_q;

    logic           hs;
    logic           single_bit;
    logic           beat_last;
    logic           last_hs;
    logic           loadable;
    logic           act_free;
    logic           pend_free;
    logic           load_act;
    logic           load_pend;
    logic           drop;
    logic [N-1:0]   mask_cleared;

    function automatic logic [AW-1:0] lowest_set(input logic [N-1:0] m);
        logic [AW-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (m[i]) r = AW'(i);
        end
        return r;
    endfunction

    assign mask_cleared = act_mask & (act_mask - {{(N-1){1'b0}}, 1'b1});
    assign single_bit   = (mask_cleared == '0);
    assign beat_last    = act_mk | single_bit;
    assign hs           = (state_q == SEND) & aer_ready;
    assign last_hs      = hs & beat_last;
    assign loadable     = step_valid & ((spikes_vec != '0) | (EMIT_EMPTY != 0));

    // Slot availability is judged after this cycle's handshake, so a step that
    // coincides with the last beat reuses the slot being vacated.
    assign act_free  = (state_q == IDLE) | (last_hs & ~pend_valid);
    assign pend_free = ~pend_valid | last_hs;
    assign load_act  = loadable & act_free;
    assign load_pend = loadable & ~act_free & pend_free;
    assign drop      = loadable & ~act_free & ~pend_free;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (load_act) state_d = SEND;
            SEND: if (last_hs && !pend_valid && !load_act) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act_mask <= '0;
            act_ts   <= '0;
            act_mk   <= 1'b0;
        end else if (load_act) begin
            act_mask <= spikes_vec;
            act_ts   <= ts_cnt;
            act_mk   <= (spikes_vec == '0);
        end else if (last_hs && pend_valid) begin
            act_mask <= pend_mask;
            act_ts   <= pend_ts;
            act_mk   <= pend_mk;
        end else if (hs) begin
            act_mask <= mask_cleared;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_valid <= 1'b0;
            pend_mask  <= '0;
            pend_ts    <= '0;
            pend_mk    <= 1'b0;
        end else if (load_pend) begin
            pend_valid <= 1'b1;
            pend_mask  <= spikes_vec;
            pend_ts    <= ts_cnt;
            pend_mk    <= (spikes_vec == '0);
        end else if (last_hs) begin
            pend_valid <= 1'b0;
        end
    end

    // Timestamp advances on every step, including ignored and dropped ones.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ts_cnt        <= '0;
            drop_cnt_q    <= '0;
            drop_sticky_q <= 1'b0;
        end else begin
            if (step_valid) ts_cnt <= ts_cnt + 1'b1;
            if (drop) begin
                drop_sticky_q <= 1'b1;
                if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    assign aer_valid   = (state_q == SEND);
    assign aer_addr    = (state_q == SEND) ? lowest_set(act_mask) : '0;
    assign aer_ts      = (state_q == SEND) ? act_ts : '0;
    assign aer_last    = (state_q == SEND) & beat_last;
    assign aer_empty   = (state_q == SEND) & act_mk;
    assign busy        = (state_q == SEND) | pend_valid;
    assign drop_cnt    = drop_cnt_q;
    assign drop_sticky = drop_sticky_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_spike_aer_tx.sv
// Directed bench for spike_aer_tx: instance A uses default parameters, instance B
// uses EMIT_EMPTY=1, TSW=4, DCW=2; beats are checked against a scoreboard queue.
module tb_spike_aer_tx;

    localparam int W = 25;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;

    logic        a_step_valid, a_ready, a_valid, a_last, a_empty, a_busy, a_sticky, a_state;
    logic [95:0] a_spikes;
    logic [6:0]  a_addr;
    logic [15:0] a_ts, a_drop_cnt;

    logic        b_step_valid, b_ready, b_valid, b_last, b_empty, b_busy, b_sticky, b_state;
    logic [95:0] b_spikes;
    logic [6:0]  b_addr;
    logic [3:0]  b_ts;
    logic [1:0]  b_drop_cnt;

    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_b[$];
    logic [15:0]  ts_a;
    logic [3:0]   ts_b;
    logic [15:0]  t_hold;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    spike_aer_tx dut_a (
        .clk(clk), .rstn(rstn), .step_valid(a_step_valid), .spikes_vec(a_spikes),
        .aer_valid(a_valid), .aer_ready(a_ready), .aer_addr(a_addr), .aer_ts(a_ts),
        .aer_last(a_last), .aer_empty(a_empty), .busy(a_busy), .drop_cnt(a_drop_cnt),
        .drop_sticky(a_sticky), .dbg_state(a_state)
    );

    spike_aer_tx #(.N(96), .TSW(4), .EMIT_EMPTY(1), .DCW(2)) dut_b (
        .clk(clk), .rstn(rstn), .step_valid(b_step_valid), .spikes_vec(b_spikes),
        .aer_valid(b_valid), .aer_ready(b_ready), .aer_addr(b_addr), .aer_ts(b_ts),
        .aer_last(b_last), .aer_empty(b_empty), .busy(b_busy), .drop_cnt(b_drop_cnt),
        .drop_sticky(b_sticky), .dbg_state(b_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] bit_at(input int i);
        logic [95:0] one;
        one = 96'd1;
        return one << i;
    endfunction

    task automatic push_frame(input bit which, input logic [95:0] v, input logic [15:0] ts,
                              input bit emit);
        int cnt;
        int k;
        logic [W-1:0] e;
        cnt = $countones(v);
        k = 0;
        if (v == '0) begin
            if (emit) begin
                e = {7'd0, ts, 1'b1, 1'b1};
                if (which) exp_b.push_back(e); else exp_a.push_back(e);
            end
        end else begin
            for (int i = 0; i < 96; i++) begin
                if (v[i]) begin
                    k++;
                    e = {7'(i), ts, (k == cnt), 1'b0};
                    if (which) exp_b.push_back(e); else exp_a.push_back(e);
                end
            end
        end
    endtask

    // Called #1 after a posedge; returns #1 after the edge that captures the step.
    task automatic step(input bit which, input logic [95:0] v, input bit load);
        if (which) begin
            b_step_valid = 1'b1;
            b_spikes = v;
            if (load) push_frame(1'b1, v, {12'd0, ts_b}, 1'b1);
            ts_b = ts_b + 4'd1;
        end else begin
            a_step_valid = 1'b1;
            a_spikes = v;
            if (load) push_frame(1'b0, v, ts_a, 1'b0);
            ts_a = ts_a + 16'd1;
        end
        @(posedge clk);
        #1;
        a_step_valid = 1'b0;
        b_step_valid = 1'b0;
        a_spikes = '0;
        b_spikes = '0;
    endtask

    task automatic wait_drain(input bit which, input bit rnd, input int max);
        int n;
        n = 0;
        while ((which ? (exp_b.size() != 0 || b_busy) : (exp_a.size() != 0 || a_busy))
               && n < max) begin
            if (rnd) begin
                if (which) b_ready = 1'($urandom_range(0, 1));
                else       a_ready = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            n++;
        end
        check(which ? "b_drain_in_time" : "a_drain_in_time", 32'(n < max), 32'd1);
        if (rnd) begin
            if (which) b_ready = 1'b1; else a_ready = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (rstn && a_valid && a_ready) begin
            if (exp_a.size() == 0) check("a_beat_unexpected", 32'(exp_a.size()), 32'd1);
            else check("a_beat", 32'({a_addr, a_ts, a_last, a_empty}), 32'(exp_a.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (rstn && b_valid && b_ready) begin
            if (exp_b.size() == 0) check("b_beat_unexpected", 32'(exp_b.size()), 32'd1);
            else check("b_beat", 32'({b_addr, 12'd0, b_ts, b_last, b_empty}),
                       32'(exp_b.pop_front()));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        a_step_valid = 1'b0; a_spikes = '0; a_ready = 1'b0;
        b_step_valid = 1'b0; b_spikes = '0; b_ready = 1'b0;
        ts_a = '0; ts_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_valid", 32'(a_valid), 32'd0);
        check("rst_a_busy", 32'(a_busy), 32'd0);
        check("rst_a_addr", 32'(a_addr), 32'd0);
        check("rst_a_ts", 32'(a_ts), 32'd0);
        check("rst_a_last", 32'(a_last), 32'd0);
        check("rst_a_drop_cnt", 32'(a_drop_cnt), 32'd0);
        check("rst_a_sticky", 32'(a_sticky), 32'd0);
        check("rst_a_state", 32'(a_state), 32'd0);
        check("rst_b_valid", 32'(b_valid), 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // T1: three bits, back-to-back beats, first beat one clock after the step
        a_ready = 1'b1;
        step(1'b0, bit_at(3) | bit_at(7) | bit_at(95), 1'b1);
        check("t1_latency_valid", 32'(a_valid), 32'd1);
        check("t1_state_send", 32'(a_state), 32'd1);
        check("t1_first_addr", 32'(a_addr), 32'd3);
        repeat (3) @(posedge clk);
        #1;
        check("t1_back_to_back", 32'(exp_a.size()), 32'd0);
        check("t1_idle_after", 32'(a_busy), 32'd0);

        // T2: backpressure, third step dropped, active beat held stable
        a_ready = 1'b0;
        t_hold = ts_a;
        step(1'b0, bit_at(10), 1'b1);
        step(1'b0, bit_at(20), 1'b1);
        step(1'b0, bit_at(30), 1'b0);
        check("t2_drop_cnt", 32'(a_drop_cnt), 32'd1);
        check("t2_sticky", 32'(a_sticky), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", 32'(a_valid), 32'd1);
            check("t2_hold_addr", 32'(a_addr), 32'd10);
            check("t2_hold_ts", 32'(a_ts), 32'(t_hold));
            check("t2_hold_last", 32'(a_last), 32'd1);
            @(posedge clk);
            #1;
        end
        a_ready = 1'b1;
        wait_drain(1'b0, 1'b0, 50);

        // T4 (EMIT_EMPTY=0): zero step loads nothing but advances the timestamp
        step(1'b0, '0, 1'b0);
        check("t4_zero_no_valid", 32'(a_valid), 32'd0);
        check("t4_zero_not_busy", 32'(a_busy), 32'd0);
        step(1'b0, bit_at(9), 1'b1);
        wait_drain(1'b0, 1'b0, 50);

        // T3: step coinciding with the last-beat handshake, pending empty
        step(1'b0, bit_at(1) | bit_at(2), 1'b1);
        @(posedge clk);
        #1;
        step(1'b0, bit_at(50), 1'b1);
        check("t3_valid_next", 32'(a_valid), 32'd1);
        check("t3_addr_new", 32'(a_addr), 32'd50);
        check("t3_no_drop", 32'(a_drop_cnt), 32'd1);
        wait_drain(1'b0, 1'b0, 50);

        // T3b: same coincidence with pending held: promote, new step to pending
        a_ready = 1'b0;
        step(1'b0, bit_at(60), 1'b1);
        step(1'b0, bit_at(61), 1'b1);
        a_ready = 1'b1;
        step(1'b0, bit_at(62), 1'b1);
        check("t3b_no_drop", 32'(a_drop_cnt), 32'd1);
        check("t3b_promoted_addr", 32'(a_addr), 32'd61);
        wait_drain(1'b0, 1'b0, 50);

        // T5: all-ones frame under random backpressure
        step(1'b0, '1, 1'b1);
        wait_drain(1'b0, 1'b1, 2000);

        // T6: reset mid-frame clears everything immediately
        step(1'b0, '1, 1'b1);
        repeat (4) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("t6_rst_valid", 32'(a_valid), 32'd0);
        check("t6_rst_busy", 32'(a_busy), 32'd0);
        check("t6_rst_addr", 32'(a_addr), 32'd0);
        check("t6_rst_last", 32'(a_last), 32'd0);
        check("t6_rst_drop_cnt", 32'(a_drop_cnt), 32'd0);
        check("t6_rst_sticky", 32'(a_sticky), 32'd0);
        exp_a.delete();
        exp_b.delete();
        ts_a = '0;
        ts_b = '0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("t6_no_beat_after_rst", 32'(a_valid), 32'd0);
        step(1'b0, bit_at(4), 1'b1);
        wait_drain(1'b0, 1'b0, 50);

        // T4 (EMIT_EMPTY=1): zero step gives one marker beat
        b_ready = 1'b1;
        step(1'b1, '0, 1'b1);
        check("t4_marker_valid", 32'(b_valid), 32'd1);
        check("t4_marker_empty", 32'(b_empty), 32'd1);
        check("t4_marker_addr", 32'(b_addr), 32'd0);
        check("t4_marker_last", 32'(b_last), 32'd1);
        wait_drain(1'b1, 1'b0, 50);

        // T6: 17 steps on the 4-bit timestamp wrap 15 -> 0
        for (int i = 0; i < 17; i++) begin
            step(1'b1, bit_at(i * 5), 1'b1);
            wait_drain(1'b1, 1'b0, 50);
        end
        check("t6_wrap_ts_model", 32'(ts_b), 32'd2);

        // Drop counter saturates at 2^DCW-1
        b_ready = 1'b0;
        step(1'b1, bit_at(1), 1'b1);
        step(1'b1, bit_at(2), 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, bit_at(3 + i), 1'b0);
        check("sat_drop_cnt", 32'(b_drop_cnt), 32'd3);
        check("sat_sticky", 32'(b_sticky), 32'd1);
        b_ready = 1'b1;
        wait_drain(1'b1, 1'b0, 50);

        check("end_a_queue_empty", 32'(exp_a.size()), 32'd0);
        check("end_b_queue_empty", 32'(exp_b.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
